red_pitaya_pid_ctrl: RTL and testbench

RED_PITAYA_PID_CTRL -- requirements
Module: red_pitaya_pid_ctrl

---
 rtl/red_pitaya_pid_pkg.sv | 17 +
 rtl/red_pitaya_pid_ramp_ch.sv | 44 ++++
 rtl/red_pitaya_pid_ctrl.sv | 141 ++++++++++++++
 tb/tb_red_pitaya_pid_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_pid_pkg.sv
// Shared definitions for the PID coefficient sequencer.
// Contents: the FSM state encoding and the default widths and counts
// used by red_pitaya_pid_ctrl and red_pitaya_pid_ramp_ch.
package red_pitaya_pid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RAMP = 2'd2,
    ST_DONE = 2'd3
  } pid_state_e;

  localparam int DW_DEF  = 14;
  localparam int TW_DEF  = 16;
  localparam int IRC_DEF = 4;

endpackage

// File: rtl/red_pitaya_pid_ramp_ch.sv
// One coefficient channel. It holds a target and an output register, and
// moves the output one LSB toward the target on each step pulse.
// Ports:
//   clk_i, rstn_i : clock, async active-low reset
//   load_i        : latch tgt_i as the new target (output is left alone)
//   tgt_i         : target value, two's complement
//   step_i        : move output one LSB toward the target
//   val_o         : registered output value
//   eq_o          : output currently equals target
module red_pitaya_pid_ramp_ch #(
  parameter int DW = 14
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          load_i,
  input  logic [DW-1:0] tgt_i,
  input  logic          step_i,
  output logic [DW-1:0] val_o,
  output logic          eq_o
);

  logic [DW-1:0] tgt_q;

  assign eq_o = (val_o == tgt_q);

  // Stepping only while unequal keeps the output inside the target's range,
  // so it can never pass the target or wrap at the signed extremes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tgt_q <= '0;
      val_o <= '0;
    end else begin
      if (load_i)
        tgt_q <= tgt_i;
      if (step_i && !eq_o) begin
        if ($signed(val_o) < $signed(tgt_q))
          val_o <= val_o + DW'(1);
        else
          val_o <= val_o - DW'(1);
      end
    end
  end

endmodule

// File: rtl/red_pitaya_pid_ctrl.sv
// Sequencer for the PID coefficients (set point, Kp, Ki, Kd). A load
// latches new targets, optionally holds the integrator in reset, and then
// ramps each output one LSB per period until all four outputs match.
// Ports:
//   clk_i, rstn_i                     : clock, async active-low reset
//   cfg_sp_i/kp_i/ki_i/kd_i           : target values
//   cfg_stp_i                         : ramp period minus one
//   cfg_irq_i                         : clear integrator with this load
//   cfg_load_i                        : single-cycle load strobe
//   abort_i                           : freeze outputs, return to idle
//   set_sp_o/kp_o/ki_o/kd_o           : registered coefficient outputs
//   int_rst_o, busy_o, done_o         : integrator reset and status
//
// state | meaning
// IDLE  | outputs hold, waiting for a load
// RST   | int_rst_o asserted for IRC cycles, outputs hold
// RAMP  | outputs step toward targets every cfg_stp+1 cycles
// DONE  | one-cycle done_o pulse, then back to IDLE
module red_pitaya_pid_ctrl
  import red_pitaya_pid_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TW  = TW_DEF,
  parameter int IRC = IRC_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] cfg_sp_i,
  input  logic [DW-1:0] cfg_kp_i,
  input  logic [DW-1:0] cfg_ki_i,
  input  logic [DW-1:0] cfg_kd_i,
  input  logic [TW-1:0] cfg_stp_i,
  input  logic          cfg_irq_i,
  input  logic          cfg_load_i,
  input  logic          abort_i,
  output logic [DW-1:0] set_sp_o,
  output logic [DW-1:0] set_kp_o,
  output logic [DW-1:0] set_ki_o,
  output logic [DW-1:0] set_kd_o,
  output logic          int_rst_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int RCW = (IRC > 1) ? $clog2(IRC) : 1;

  pid_state_e    state_q, state_d;
  logic [TW-1:0] stp_q;
  logic [TW-1:0] per_cnt_q;
  logic [RCW-1:0] rst_cnt_q;
  logic [3:0]    eq;
  logic          all_eq;
  logic          load_acc;
  logic          tick;

  assign all_eq   = &eq;
  assign load_acc = cfg_load_i && !abort_i;
  // No step on a load or abort cycle: a new load restarts the period,
  // and an abort freezes outputs at their current values.
  assign tick     = (state_q == ST_RAMP) && !abort_i && !cfg_load_i &&
                    !all_eq && (per_cnt_q == '0);

  always_comb begin
    state_d = state_q;
    if (abort_i)
      state_d = ST_IDLE;
    else if (cfg_load_i)
      state_d = cfg_irq_i ? ST_RST : ST_RAMP;
    else begin
      case (state_q)
        ST_RST:  if (rst_cnt_q == '0) state_d = ST_RAMP;
        ST_RAMP: if (all_eq) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up
  // with the state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      stp_q     <= '0;
      per_cnt_q <= '0;
      rst_cnt_q <= '0;
      int_rst_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_rst_o <= (state_d == ST_RST);
      busy_o    <= (state_d == ST_RST) || (state_d == ST_RAMP);
      done_o    <= (state_d == ST_DONE);
      if (abort_i) begin
        per_cnt_q <= per_cnt_q;
      end else if (cfg_load_i) begin
        stp_q     <= cfg_stp_i;
        per_cnt_q <= cfg_stp_i;
        rst_cnt_q <= RCW'(IRC - 1);
      end else begin
        case (state_q)
          ST_RST: begin
            if (rst_cnt_q == '0)
              per_cnt_q <= stp_q;
            else
              rst_cnt_q <= rst_cnt_q - RCW'(1);
          end
          ST_RAMP: begin
            if (per_cnt_q == '0)
              per_cnt_q <= stp_q;
            else
              per_cnt_q <= per_cnt_q - TW'(1);
          end
          default: per_cnt_q <= per_cnt_q;
        endcase
      end
    end
  end

  red_pitaya_pid_ramp_ch #(.DW(DW)) u_ch_sp (
    .clk_i(clk_i), .rstn_i(rstn_i), .load_i(load_acc), .tgt_i(cfg_sp_i),
    .step_i(tick), .val_o(set_sp_o), .eq_o(eq[0])
  );

  red_pitaya_pid_ramp_ch #(.DW(DW)) u_ch_kp (
    .clk_i(clk_i), .rstn_i(rstn_i), .load_i(load_acc), .tgt_i(cfg_kp_i),
    .step_i(tick), .val_o(set_kp_o), .eq_o(eq[1])
  );

  red_pitaya_pid_ramp_ch #(.DW(DW)) u_ch_ki (
    .clk_i(clk_i), .rstn_i(rstn_i), .load_i(load_acc), .tgt_i(cfg_ki_i),
    .step_i(tick), .val_o(set_ki_o), .eq_o(eq[2])
  );

  red_pitaya_pid_ramp_ch #(.DW(DW)) u_ch_kd (
    .clk_i(clk_i), .rstn_i(rstn_i), .load_i(load_acc), .tgt_i(cfg_kd_i),
    .step_i(tick), .val_o(set_kd_o), .eq_o(eq[3])
  );

endmodule

// File: tb/tb_red_pitaya_pid_ctrl.sv
// Directed bench for red_pitaya_pid_ctrl. Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_red_pitaya_pid_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [13:0] cfg_sp_i, cfg_kp_i, cfg_ki_i, cfg_kd_i;
  logic [15:0] cfg_stp_i;
  logic        cfg_irq_i, cfg_load_i, abort_i;
  logic [13:0] set_sp_o, set_kp_o, set_ki_o, set_kd_o;
  logic        int_rst_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  red_pitaya_pid_ctrl #(.DW(14), .TW(16), .IRC(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_sp_i(cfg_sp_i), .cfg_kp_i(cfg_kp_i), .cfg_ki_i(cfg_ki_i), .cfg_kd_i(cfg_kd_i),
    .cfg_stp_i(cfg_stp_i), .cfg_irq_i(cfg_irq_i), .cfg_load_i(cfg_load_i), .abort_i(abort_i),
    .set_sp_o(set_sp_o), .set_kp_o(set_kp_o), .set_ki_o(set_ki_o), .set_kd_o(set_kd_o),
    .int_rst_o(int_rst_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input int sp, input int kp, input int ki, input int kd,
                      input int stp, input bit irq);
    cfg_sp_i   = sp[13:0];
    cfg_kp_i   = kp[13:0];
    cfg_ki_i   = ki[13:0];
    cfg_kd_i   = kd[13:0];
    cfg_stp_i  = stp[15:0];
    cfg_irq_i  = irq;
    cfg_load_i = 1'b1;
    cyc();
    cfg_load_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (!done_o && n < max_cyc) begin
      cyc();
      n++;
    end
    chk(tag, int'(done_o), 1);
  endtask

  initial begin
    rstn_i = 1'b0;
    cfg_sp_i = '0; cfg_kp_i = '0; cfg_ki_i = '0; cfg_kd_i = '0;
    cfg_stp_i = '0; cfg_irq_i = 1'b0; cfg_load_i = 1'b0; abort_i = 1'b0;
    repeat (3) cyc();
    chk("rst_kp", int'(set_kp_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_intrst", int'(int_rst_o), 0);
    rstn_i = 1'b1;
    cyc();

    // kp 0 -> 3, period 2: updates visible in RAMP cycles 3,5,7; DONE in cycle 8
    load(0, 3, 0, 0, 1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("ramp_kp_c%0d", i), int'(set_kp_o), (i - 1) / 2);
      chk($sformatf("ramp_busy_c%0d", i), int'(busy_o), 1);
      chk($sformatf("ramp_done_c%0d", i), int'(done_o), 0);
      cyc();
    end
    chk("ramp_done", int'(done_o), 1);
    chk("ramp_busy_low", int'(busy_o), 0);
    chk("ramp_kp_final", int'(set_kp_o), 3);
    cyc();
    chk("ramp_done_pulse", int'(done_o), 0);

    // integrator clear with no change: 4 RST cycles, 1 RAMP cycle, DONE
    load(0, 3, 0, 0, 0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("irq_intrst_c%0d", i), int'(int_rst_o), 1);
      chk($sformatf("irq_busy_c%0d", i), int'(busy_o), 1);
      cyc();
    end
    chk("irq_intrst_off", int'(int_rst_o), 0);
    chk("irq_ramp_nodone", int'(done_o), 0);
    cyc();
    chk("irq_done", int'(done_o), 1);
    chk("irq_kp_same", int'(set_kp_o), 3);
    cyc();

    // negative ramp sp 0 -> -5 at one step per cycle
    load(-5, 3, 0, 0, 0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("neg_sp_c%0d", i), $signed(set_sp_o), -(i - 1));
      cyc();
    end
    chk("neg_done", int'(done_o), 1);
    chk("neg_sp_hold", $signed(set_sp_o), -5);
    cyc();
    chk("neg_sp_no_overshoot", $signed(set_sp_o), -5);

    // range limits: sp to 8190 then 8191, ki to -8192
    load(8190, 3, -8192, 0, 0, 1'b0);
    wait_done(9000, "lim_done1");
    chk("lim_sp_8190", $signed(set_sp_o), 8190);
    chk("lim_ki_min", $signed(set_ki_o), -8192);
    cyc();
    load(8191, 3, -8192, 0, 0, 1'b0);
    wait_done(10, "lim_done2");
    chk("lim_sp_max", $signed(set_sp_o), 8191);
    cyc();
    cyc();
    chk("lim_sp_no_wrap", $signed(set_sp_o), 8191);
    chk("lim_ki_no_wrap", $signed(set_ki_o), -8192);

    // retarget mid-ramp: kp heading to 20, reload to 5 at kp=10
    load(8191, 20, -8192, 0, 0, 1'b0);
    repeat (7) cyc();
    chk("re_kp_at10", int'(set_kp_o), 10);
    load(8191, 5, -8192, 0, 0, 1'b0);
    chk("re_kp_nojump", int'(set_kp_o), 10);
    for (int j = 9; j >= 5; j--) begin
      cyc();
      chk($sformatf("re_kp_%0d", j), int'(set_kp_o), j);
      chk($sformatf("re_nodone_%0d", j), int'(done_o), 0);
    end
    cyc();
    chk("re_done", int'(done_o), 1);
    cyc();
    chk("re_done_single", int'(done_o), 0);

    // abort at kp=7 while heading to 20
    load(8191, 20, -8192, 0, 0, 1'b0);
    cyc();
    cyc();
    chk("ab_kp7", int'(set_kp_o), 7);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("ab_busy_low", int'(busy_o), 0);
    chk("ab_kp_hold", int'(set_kp_o), 7);
    repeat (3) begin
      cyc();
      chk("ab_kp_still", int'(set_kp_o), 7);
      chk("ab_nodone", int'(done_o), 0);
    end
    // abort wins over a simultaneous load
    cfg_kp_i = 14'd0; cfg_irq_i = 1'b1; cfg_load_i = 1'b1; abort_i = 1'b1;
    cyc();
    cfg_load_i = 1'b0; abort_i = 1'b0;
    chk("abld_busy", int'(busy_o), 0);
    chk("abld_intrst", int'(int_rst_o), 0);
    cyc();
    chk("abld_kp", int'(set_kp_o), 7);
    chk("abld_busy2", int'(busy_o), 0);

    // async reset in the middle of RST
    load(8191, 12, -8192, 0, 0, 1'b1);
    cyc();
    chk("ar_in_rst", int'(int_rst_o), 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("ar_intrst", int'(int_rst_o), 0);
    chk("ar_kp", int'(set_kp_o), 0);
    chk("ar_sp", int'(set_sp_o), 0);
    chk("ar_busy", int'(busy_o), 0);
    cyc();
    rstn_i = 1'b1;
    repeat (6) begin
      cyc();
      chk("ar_idle_busy", int'(busy_o), 0);
      chk("ar_idle_kp", int'(set_kp_o), 0);
      chk("ar_idle_intrst", int'(int_rst_o), 0);
      chk("ar_idle_done", int'(done_o), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
